// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter in front of the shared Memory.
// Registered memory drive, one-cycle ack, IDLE -> ACCESS -> ACK cycle.
module mem_arbiter #(
  parameter int   ADDR_W     = 17,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [32-ADDR_W:31]  addr0,
  input  logic [32-ADDR_W:31]  addr1,
  input  logic [0:3]           wr_en0,
  input  logic [0:3]           wr_en1,
  input  logic [0:31]          wdata0,
  input  logic [0:31]          wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [0:31]          rdata,
  output logic                 busy,
  output logic [32-ADDR_W:31]  mem_addr,
  output logic [0:3]           mem_wr_en,
  output logic [0:31]          mem_wdata,
  input  logic [0:31]          mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   winner;
  logic   pick1;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      (req1 && !req0): pick1 = 1'b1;
      (req1 && req0):  pick1 = ~last;
      default:         pick1 = 1'b0;
    endcase
  end

  // Transaction sequencer with registered memory drive and ack outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= RESET_LAST;
      winner    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wr_en <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner    <= pick1;
            last      <= pick1;
            mem_addr  <= pick1 ? addr1  : addr0;
            mem_wr_en <= pick1 ? wr_en1 : wr_en0;
            mem_wdata <= pick1 ? wdata1 : wdata0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rdata     <= mem_rdata;
          mem_wr_en <= '0;
          ack0      <= ~winner;
          ack1      <= winner;
          state     <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          busy      <= 1'b0;
          mem_wr_en <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte-lane memory.
// Memory is modelled here with combinational read and posedge write.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [15:31] addr0, addr1;
  logic [0:3]   wr_en0, wr_en1;
  logic [0:31]  wdata0, wdata1;
  logic         ack0, ack1;
  logic [0:31]  rdata;
  logic         busy;
  logic [15:31] mem_addr;
  logic [0:3]   mem_wr_en;
  logic [0:31]  mem_wdata;
  logic [0:31]  mem_rdata;

  logic [0:31]  mem [0:131071];
  logic         pre_en;
  logic [15:31] pre_addr;
  logic [0:31]  pre_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(17), .RESET_LAST(1'b1)) dut (
    .clock(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else for (int i = 0; i < 4; i++)
      if (mem_wr_en[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:31] a, input logic [0:31] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL reset_ack got=%b%b exp=00", ack0, ack1); end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_wr_en !== 4'b0000) begin
      errors++; $display("FAIL reset_wr_en got=%b exp=0000", mem_wr_en); end
    checks++; if (mem_addr !== 17'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    checks++; if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (ack0 || ack1 || busy || mem_wr_en !== 4'b0 || rdata !== 32'h0
          || mem_addr !== 17'h0) begin
        errors++;
        $display("FAIL idle_hold c=%0d got ack=%b%b busy=%b we=%b rd=%h exp=idle",
                 c, ack0, ack1, busy, mem_wr_en, rdata);
      end
    end
  endtask

  task automatic test_single_read();
    preload(17'h05, 32'h12345678);
    addr0 = 17'h05; wr_en0 = 4'b0000; wdata0 = 32'h0; req0 = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || ack0 !== 1'b0 || mem_addr !== 17'h05) begin
      errors++; $display("FAIL read_access got busy=%b ack0=%b addr=%h exp=1/0/05",
                         busy, ack0, mem_addr); end
    checks++; if (mem_wr_en !== 4'b0000) begin
      errors++; $display("FAIL read_we_access got=%b exp=0000", mem_wr_en); end
    tick();
    req0 = 1'b0;
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      errors++; $display("FAIL read_ack got=%b%b exp=10", ack0, ack1); end
    checks++; if (rdata !== 32'h12345678) begin
      errors++; $display("FAIL read_rdata got=%h exp=12345678", rdata); end
    checks++; if (mem_wr_en !== 4'b0000) begin
      errors++; $display("FAIL read_we_ack got=%b exp=0000", mem_wr_en); end
    tick();
    checks++; if (ack0 !== 1'b0 || busy !== 1'b0 || rdata !== 32'h12345678) begin
      errors++; $display("FAIL read_after got ack0=%b busy=%b rd=%h exp=0/0/12345678",
                         ack0, busy, rdata); end
  endtask

  task automatic test_byte_write();
    int n1 = 0;
    int n0 = 0;
    preload(17'h10, 32'h11223344);
    addr1 = 17'h10; wr_en1 = 4'b0101; wdata1 = 32'hAABBCCDD; req1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack1) begin n1++; req1 = 1'b0; end
      if (ack0) n0++;
    end
    checks++; if (n1 != 1 || n0 != 0) begin
      errors++; $display("FAIL bytewr_ack got ack1=%0d ack0=%0d exp=1/0", n1, n0); end
    checks++; if (mem[17'h10] !== 32'h11BB33DD) begin
      errors++; $display("FAIL bytewr_data got=%h exp=11BB33DD", mem[17'h10]); end
  endtask

  task automatic test_contention();
    int grants[$];
    int acc_at[$];
    logic pa0, pa1;
    test_reset();
    pa0 = 1'b0; pa1 = 1'b0;
    addr0 = 17'h05; wr_en0 = 4'b0; addr1 = 17'h10; wr_en1 = 4'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (busy && !ack0 && !ack1) acc_at.push_back(c);
      if (ack0) grants.push_back(0);
      if (ack1) grants.push_back(1);
      checks++; if ((ack0 && pa0) || (ack1 && pa1) || (ack0 && ack1)) begin
        errors++; $display("FAIL cont_ack_len c=%0d got=%b%b exp=single", c, ack0, ack1); end
      pa0 = ack0; pa1 = ack1;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (grants.size() != 4) begin
      errors++; $display("FAIL cont_count got=%0d exp=4", grants.size()); end
    else begin
      checks++; if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
        errors++; $display("FAIL cont_order got=%0d%0d%0d%0d exp=0101",
                           grants[0], grants[1], grants[2], grants[3]); end
    end
    checks++; if (acc_at.size() != 4) begin
      errors++; $display("FAIL cont_access got=%0d exp=4", acc_at.size()); end
    else begin
      checks++; if (acc_at[0] != 1 || acc_at[1] != 4 || acc_at[2] != 7 || acc_at[3] != 10) begin
        errors++; $display("FAIL cont_spacing got=%0d,%0d,%0d,%0d exp=1,4,7,10",
                           acc_at[0], acc_at[1], acc_at[2], acc_at[3]); end
    end
    tick(); tick();
  endtask

  task automatic test_late_request();
    preload(17'h33, 32'h0BADF00D);
    addr0 = 17'h33; wr_en0 = 4'b0000; req0 = 1'b1;
    tick();
    addr1 = 17'h44; wr_en1 = 4'b1111; wdata1 = 32'hCAFEF00D; req1 = 1'b1;
    #1;
    checks++; if (mem_addr !== 17'h33 || mem_wr_en !== 4'b0000) begin
      errors++; $display("FAIL late_p0_access got=%h/%b exp=33/0000", mem_addr, mem_wr_en); end
    tick();
    req0 = 1'b0;
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL late_ack0 got=%b%b rd=%h exp=10/0BADF00D", ack0, ack1, rdata); end
    tick();
    checks++; if (busy !== 1'b0 || ack0 !== 1'b0) begin
      errors++; $display("FAIL late_idle got busy=%b ack0=%b exp=0/0", busy, ack0); end
    tick();
    checks++; if (busy !== 1'b1 || mem_addr !== 17'h44 || mem_wr_en !== 4'b1111
                  || mem_wdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL late_p1_access got busy=%b a=%h we=%b d=%h exp=1/44/1111/CAFEF00D",
                         busy, mem_addr, mem_wr_en, mem_wdata); end
    tick();
    req1 = 1'b0;
    checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0 || mem_wr_en !== 4'b0000) begin
      errors++; $display("FAIL late_ack1 got=%b%b we=%b exp=01/0000", ack0, ack1, mem_wr_en); end
    checks++; if (mem[17'h44] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL late_mem got=%h exp=CAFEF00D", mem[17'h44]); end
    tick();
  endtask

  task automatic test_reset_during_write();
    int nack = 0;
    addr0 = 17'h20; wr_en0 = 4'b1111; wdata0 = 32'hDEADBEEF; req0 = 1'b1;
    tick();
    checks++; if (mem_wr_en !== 4'b1111) begin
      errors++; $display("FAIL rstwr_access got=%b exp=1111", mem_wr_en); end
    req0 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (mem[17'h20] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rstwr_mem got=%h exp=DEADBEEF", mem[17'h20]); end
    checks++; if (busy !== 1'b0 || mem_wr_en !== 4'b0000 || rdata !== 32'h0) begin
      errors++; $display("FAIL rstwr_state got busy=%b we=%b rd=%h exp=0/0000/0",
                         busy, mem_wr_en, rdata); end
    if (ack0 || ack1) nack++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack0 || ack1) nack++;
    end
    checks++; if (nack != 0) begin
      errors++; $display("FAIL rstwr_noack got=%0d exp=0", nack); end
  endtask

  initial begin
    reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; wr_en0 = '0; wr_en1 = '0;
    wdata0 = '0; wdata1 = '0;
    test_reset();
    test_idle_hold();
    test_single_read();
    test_byte_write();
    test_contention();
    test_late_request();
    test_reset_during_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
